// File: rtl/rssi_frame_pkg.sv
// rtl/rssi_frame_pkg.sv - shared types and constants for the RSSI frame sequencer
package rssi_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        SEND
    } seq_state_t;

    localparam int FRAME_LEN = 6;

    // Byte positions inside the UART frame
    localparam logic [2:0] IDX_SYNC   = 3'd0;
    localparam logic [2:0] IDX_SEQ    = 3'd1;
    localparam logic [2:0] IDX_STATUS = 3'd2;
    localparam logic [2:0] IDX_DB_HI  = 3'd3;
    localparam logic [2:0] IDX_DB_LO  = 3'd4;
    localparam logic [2:0] IDX_CHK    = 3'(FRAME_LEN - 1);

    // STATUS byte bit positions
    localparam int ST_TIMEOUT = 0;
    localparam int ST_DROP    = 1;

endpackage

// File: rtl/rssi_frame_sequencer_wait_timer.sv
// rtl/rssi_frame_sequencer_wait_timer.sv - result wait timer with one-cycle expiry flag
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : synchronous clear of the count
//   enable_i     : count while high
//   expired_o    : high for the cycle in which the count sits at TERMINAL_COUNT-1
//                  while enabled
module wait_timer #(
    parameter int TERMINAL_COUNT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = $clog2(TERMINAL_COUNT);

    logic [W-1:0] count_q;

    assign expired_o = enable_i && (count_q == W'(TERMINAL_COUNT - 1));

    // The count holds at the terminal value so it can never wrap if the
    // enable stays high for longer than expected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && !expired_o) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/rssi_frame_sequencer.sv
// rtl/rssi_frame_sequencer.sv - measurement sequencer and 6-byte UART framer for dB power results
//
// Ports:
//   clk, rst          : 125 MHz clock, asynchronous active-high reset
//   enable_i          : run measurements back-to-back while high (sampled in IDLE)
//   goertzel_start_o  : one-cycle start pulse to the Goertzel power stage
//   db_i, db_valid_i  : dB result and its one-cycle qualifier
//   uart_data_o       : frame byte presented to the UART FIFO
//   uart_wr_en_o      : FIFO write strobe, one byte per high cycle
//   uart_fifo_full_i  : FIFO full backpressure
//   busy_o            : high whenever not IDLE
//   drop_cnt_o        : saturating count of results arriving outside WAIT
module rssi_frame_sequencer
    import rssi_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    output logic        goertzel_start_o,
    input  logic [15:0] db_i,
    input  logic        db_valid_i,
    output logic [7:0]  uart_data_o,
    output logic        uart_wr_en_o,
    input  logic        uart_fifo_full_i,
    output logic        busy_o,
    output logic [7:0]  drop_cnt_o
);

    seq_state_t  state;
    logic [2:0]  byte_idx;
    logic [7:0]  seq_q;
    logic [7:0]  chk_q;
    logic [15:0] db_q;
    logic        timeout_q;
    logic        drop_flag_q;
    logic        timer_expired;
    logic        drop;
    logic [7:0]  status_byte;
    logic [7:0]  frame_byte;

    wait_timer #(
        .TERMINAL_COUNT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state == START),
        .enable_i (state == WAIT),
        .expired_o(timer_expired)
    );

    assign drop         = db_valid_i && (state != WAIT);
    assign uart_wr_en_o = (state == SEND) && !uart_fifo_full_i;
    assign uart_data_o  = (state == SEND) ? frame_byte : 8'h00;

    always_comb begin
        status_byte             = 8'h00;
        status_byte[ST_TIMEOUT] = timeout_q;
        status_byte[ST_DROP]    = drop_flag_q;
    end

    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            IDX_SYNC:   frame_byte = SYNC_BYTE;
            IDX_SEQ:    frame_byte = seq_q;
            IDX_STATUS: frame_byte = status_byte;
            IDX_DB_HI:  frame_byte = db_q[15:8];
            IDX_DB_LO:  frame_byte = db_q[7:0];
            IDX_CHK:    frame_byte = chk_q;
            default:    frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            goertzel_start_o <= 1'b0;
            busy_o           <= 1'b0;
            drop_cnt_o       <= 8'h00;
            byte_idx         <= IDX_SYNC;
            seq_q            <= 8'h00;
            chk_q            <= 8'h00;
            db_q             <= 16'h0000;
            timeout_q        <= 1'b0;
            drop_flag_q      <= 1'b0;
        end else begin
            goertzel_start_o <= 1'b0;

            if (drop && (drop_cnt_o != 8'hFF)) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end

            // A drop coinciding with the STATUS write survives into the next frame.
            if (drop) begin
                drop_flag_q <= 1'b1;
            end else if (uart_wr_en_o && (byte_idx == IDX_STATUS)) begin
                drop_flag_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state            <= START;
                        goertzel_start_o <= 1'b1;
                        busy_o           <= 1'b1;
                    end
                end

                START: begin
                    state    <= WAIT;
                    byte_idx <= IDX_SYNC;
                    chk_q    <= 8'h00;
                end

                WAIT: begin
                    // A result on the expiry cycle takes priority over the timeout.
                    if (db_valid_i) begin
                        db_q      <= db_i;
                        timeout_q <= 1'b0;
                        state     <= SEND;
                    end else if (timer_expired) begin
                        db_q      <= 16'h0000;
                        timeout_q <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (uart_wr_en_o) begin
                        if (byte_idx == IDX_CHK) begin
                            byte_idx <= IDX_SYNC;
                            seq_q    <= seq_q + 8'd1;
                            state    <= IDLE;
                            busy_o   <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            // Checksum folds in the bytes as actually written.
                            if (byte_idx != IDX_SYNC) begin
                                chk_q <= chk_q ^ frame_byte;
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rssi_frame_sequencer.sv
// tb/tb_rssi_frame_sequencer.sv - self-checking bench for rssi_frame_sequencer
module tb_rssi_frame_sequencer;

    localparam int         TC   = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic        goertzel_start_o;
    logic [15:0] db_i = 16'h0000;
    logic        db_valid_i = 1'b0;
    logic [7:0]  uart_data_o;
    logic        uart_wr_en_o;
    logic        uart_fifo_full_i = 1'b0;
    logic        busy_o;
    logic [7:0]  drop_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$];

    // Reference model state
    int exp_seq;
    bit exp_flag;
    int exp_drops;

    typedef struct {
        logic [15:0] db;
        int          delay;
        bit          tmo;
        int          lat;
        logic [47:0] frame;
    } vec_t;
    vec_t tbl[5];

    rssi_frame_sequencer #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_i(enable_i),
        .goertzel_start_o(goertzel_start_o),
        .db_i(db_i),
        .db_valid_i(db_valid_i),
        .uart_data_o(uart_data_o),
        .uart_wr_en_o(uart_wr_en_o),
        .uart_fifo_full_i(uart_fifo_full_i),
        .busy_o(busy_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (uart_wr_en_o) begin
            wr_q.push_back(uart_data_o);
            wr_cyc.push_back(cyc);
        end
        if (goertzel_start_o) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        enable_i = 0; db_valid_i = 0; uart_fifo_full_i = 0; db_i = 16'h0000;
        rst = 1;
        step(); step();
        check("rst_start", goertzel_start_o, 0);
        check("rst_wr_en", uart_wr_en_o, 0);
        check("rst_data", uart_data_o, 8'h00);
        check("rst_busy", busy_o, 0);
        check("rst_drop_cnt", drop_cnt_o, 8'h00);
        rst = 0;
        step();
        exp_seq = 0; exp_flag = 0; exp_drops = 0;
    endtask

    // Runs one measurement from IDLE and compares the written bytes with exp_frame.
    task automatic run_frame(input logic [15:0] db, input int delay, input bit tmo, input bit stall,
                             input int ndrop, input bit rand_bp, input logic [47:0] exp_frame,
                             input int exp_lat, input string tag);
        int budget;
        logic [7:0] b;
        wr_q.delete(); wr_cyc.delete(); start_cnt = 0;
        enable_i = 1;
        step();
        enable_i = 0;
        if (!tmo) begin
            repeat (delay) step();
            db_i = db; db_valid_i = 1;
            step();
            db_valid_i = 0; db_i = 16'($urandom());
            if (!rand_bp) begin
                for (int k = 1; k <= 6; k++) begin
                    db_valid_i = (k >= 4) && (k < 4 + ndrop);
                    if (stall && k == 3) begin
                        uart_fifo_full_i = 1;
                        for (int i = 0; i < 10; i++) begin
                            #2;
                            check({tag, "_stall_wr_en"}, uart_wr_en_o, 0);
                            check({tag, "_stall_data"}, uart_data_o, exp_frame[31:24]);
                            step();
                        end
                        uart_fifo_full_i = 0;
                    end
                    step();
                end
                db_valid_i = 0;
            end
        end
        budget = TC + 200;
        while (!(wr_q.size() >= 6 && !busy_o) && budget > 0) begin
            if (rand_bp) uart_fifo_full_i = ($urandom_range(0, 2) == 0);
            step();
            budget--;
        end
        uart_fifo_full_i = 0;
        check({tag, "_done_in_time"}, budget > 0, 1);
        check({tag, "_len"}, wr_q.size(), 6);
        check({tag, "_starts"}, start_cnt, 1);
        for (int i = 0; i < 6; i++) begin
            b = 8'hxx;
            if (i < wr_q.size()) b = wr_q[i];
            check($sformatf("%s_byte%0d", tag, i), b, exp_frame[47 - 8*i -: 8]);
        end
        if (!rand_bp && wr_cyc.size() >= 6) begin
            check({tag, "_sync_latency"}, wr_cyc[0] - start_cyc, exp_lat);
            check({tag, "_span"}, wr_cyc[5] - wr_cyc[0], stall ? 15 : 5);
        end
    endtask

    // Frame driven through the reference model: expectations follow from the
    // framing rules applied to the bench's own seq / drop bookkeeping.
    task automatic frame_m(input logic [15:0] db, input int delay, input bit tmo, input bit stall,
                           input int ndrop, input bit rand_bp, input string tag);
        logic [7:0]  s, st;
        logic [15:0] cap;
        s   = 8'(exp_seq);
        cap = tmo ? 16'h0000 : db;
        st  = {6'b0, exp_flag, tmo};
        run_frame(db, delay, tmo, stall, ndrop, rand_bp,
                  {SYNC, s, st, cap, s ^ st ^ cap[15:8] ^ cap[7:0]},
                  tmo ? TC + 1 : delay + 1, tag);
        exp_seq   = (exp_seq + 1) % 256;
        exp_flag  = (ndrop > 0);
        exp_drops = (exp_drops + ndrop > 255) ? 255 : exp_drops + ndrop;
        check({tag, "_drop_cnt"}, drop_cnt_o, exp_drops);
    endtask

    initial begin
        logic [15:0] rd;
        int          rdl;
        bit          rtmo;

        tbl[0] = '{16'h1234,  50, 1'b0,  51, 48'hA5_00_00_12_34_26};
        tbl[1] = '{16'h0000,   0, 1'b1, 101, 48'hA5_01_01_00_00_00};
        tbl[2] = '{16'hABCD,   1, 1'b0,   2, 48'hA5_02_00_AB_CD_64};
        tbl[3] = '{16'hFFFF, 100, 1'b0, 101, 48'hA5_03_00_FF_FF_03};
        tbl[4] = '{16'h0F0F,  99, 1'b0, 100, 48'hA5_04_00_0F_0F_04};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].db, tbl[i].delay, tbl[i].tmo, 1'b0, 0, 1'b0,
                      tbl[i].frame, tbl[i].lat, $sformatf("tbl%0d", i));
        end

        // Timeout as first frame, then a STATUS stall of 10 cycles
        do_reset();
        frame_m(16'h0000, 0, 1'b1, 1'b0, 0, 1'b0, "timeout");
        frame_m(16'h5AC3, 20, 1'b0, 1'b1, 0, 1'b0, "stall");

        // Three drops after STATUS, flagged in the next frame
        do_reset();
        frame_m(16'h0102, 5, 1'b0, 1'b0, 3, 1'b0, "drop3");
        frame_m(16'h0304, 5, 1'b0, 1'b0, 0, 1'b0, "after_drop3");
        check("after_drop3_status", (wr_q.size() > 2) ? wr_q[2] : 8'hxx, 8'h02);

        // Drop counter saturation in IDLE
        do_reset();
        for (int i = 0; i < 300; i++) begin
            db_valid_i = 1;
            step();
            db_valid_i = 0;
            step();
            if (i == 253) check("drop_cnt_254", drop_cnt_o, 8'hFE);
        end
        check("drop_cnt_sat", drop_cnt_o, 8'hFF);
        exp_drops = 255;
        exp_flag  = 1;
        frame_m(16'h7777, 3, 1'b0, 1'b0, 0, 1'b0, "after_sat");

        // Randomised frames across the SEQ wrap
        do_reset();
        for (int f = 0; f < 257; f++) begin
            rd   = 16'($urandom());
            rtmo = ($urandom_range(0, 7) == 0);
            rdl  = ($urandom_range(0, 9) == 0) ? TC : $urandom_range(1, 40);
            frame_m(rd, rdl, rtmo, 1'b0, 0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
            if (f == 255) check("seq_frame256", (wr_q.size() > 1) ? wr_q[1] : 8'hxx, 8'hFF);
            if (f == 256) check("seq_frame257", (wr_q.size() > 1) ? wr_q[1] : 8'hxx, 8'h00);
        end

        // Reset in the middle of SEND, right after the DB[15:8] write
        do_reset();
        db_valid_i = 1;
        step();
        db_valid_i = 0;
        check("mid_pre_drop_cnt", drop_cnt_o, 8'h01);
        wr_q.delete(); wr_cyc.delete();
        enable_i = 1;
        step();
        enable_i = 0;
        repeat (7) step();
        db_i = 16'hBEEF; db_valid_i = 1;
        step();
        db_valid_i = 0;
        repeat (4) step();
        check("mid_pre_wr_en", uart_wr_en_o, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_start", goertzel_start_o, 0);
        check("mid_rst_wr_en", uart_wr_en_o, 0);
        check("mid_rst_data", uart_data_o, 8'h00);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_drop_cnt", drop_cnt_o, 8'h00);
        step(); step();
        rst = 0;
        repeat (10) step();
        check("mid_rst_writes", wr_q.size(), 4);
        check("mid_rst_last_byte", (wr_q.size() > 3) ? wr_q[3] : 8'hxx, 8'hBE);
        exp_seq = 0; exp_flag = 0; exp_drops = 0;
        frame_m(16'h2468, 10, 1'b0, 1'b0, 0, 1'b0, "after_mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
